// File: rtl/jtag_bus_support_pkg.sv
// Shared definitions for the JTAG-to-bus DMA bridge.
//   - chain 1 instruction opcodes (low nibble of the 36-bit instruction)
//   - DMA state encoding
//   - status word bit positions
//   - burst_beats(): turns the raw burst register into a legal beat count
package jtag_bus_support_pkg;

  localparam logic [3:0] OP_STATUS = 4'b0000;
  localparam logic [3:0] OP_ADDR   = 4'b0001;
  localparam logic [3:0] OP_BE     = 4'b0010;
  localparam logic [3:0] OP_BURST  = 4'b0011;
  localparam logic [3:0] OP_WRITE  = 4'b1000;
  localparam logic [3:0] OP_READ   = 4'b1001;
  localparam logic [3:0] OP_POP    = 4'b1010;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_REQ   = 3'd1,
    DMA_BEGIN = 3'd2,
    DMA_WDATA = 3'd3,
    DMA_RDATA = 3'd4,
    DMA_END   = 3'd5
  } dma_state_e;

  localparam int ST_ACTIVE     = 0;
  localparam int ST_ERROR      = 1;
  localparam int ST_REQUEST    = 2;
  localparam int ST_WCOUNT_LSB = 8;
  localparam int ST_RCOUNT_LSB = 16;
  localparam int ST_COUNT_W    = 5;

  // A zero burst still moves one beat; anything past the FIFO size is
  // clamped so a write can never wait for more words than the FIFO holds.
  function automatic logic [7:0] burst_beats(input logic [7:0] burst, input int depth);
    if (burst == 8'd0) return 8'd1;
    if (int'(burst) > depth) return 8'(depth);
    return burst;
  endfunction

endpackage

// File: rtl/jtag_word_fifo.sv
// Synchronous 32-bit word FIFO with occupancy count.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data   write a word; ignored when full
//   pop               drop the head word; ignored when empty
//   head              current head word (valid when !empty)
//   count, full, empty occupancy
module jtag_word_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop,
  output logic [31:0]   head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/jtag_bus_support.sv
// JTAG user-register to system-bus DMA master.
// Ports:
//   system_clock, JRSTN        sole clock, asynchronous active-low reset
//   JTCK/JTDI/JSHIFT/JUPDATE/JCE1/JCE2/JRTI1/JRTI2
//                              JTAG primitive signals, oversampled as data
//   JTDO1, JTDO2               chain 1 shift-register LSB, chain 2 bypass flop
//   *OUT bus outputs, *IN bus inputs, request/granted arbiter handshake
//
// Bus handshake: request is held until granted is seen high on a clock
// edge. The next cycle is the one-cycle begin phase (begin_transactionOUT
// with address, byte enables, beats-1 and direction). A write beat is
// offered by data_validOUT with the word on address_dataOUT and counts as
// transferred only on an edge where busyIN is low; otherwise it is held.
// A write closes with a one-cycle end_transactionOUT. A read accepts a
// word on every edge with data_validIN and closes on end_transactionIN.
// errorIN during any bus phase aborts back to idle.
module jtag_bus_support
  import jtag_bus_support_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        system_clock,
  input  logic        JRSTN,
  input  logic        JTCK,
  input  logic        JTDI,
  input  logic        JSHIFT,
  input  logic        JUPDATE,
  input  logic        JCE1,
  input  logic        JCE2,
  input  logic        JRTI1,
  input  logic        JRTI2,
  output logic        JTDO1,
  output logic        JTDO2,
  output logic [31:0] address_dataOUT,
  output logic [3:0]  byte_enableOUT,
  output logic [7:0]  busrt_sizeOUT,
  output logic        read_n_writeOUT,
  output logic        begin_transactionOUT,
  output logic        end_transactionOUT,
  output logic        data_validOUT,
  output logic        busyOUT,
  input  logic [31:0] address_dataIN,
  input  logic        end_transactionIN,
  input  logic        data_validIN,
  input  logic        busyIN,
  input  logic        errorIN,
  output logic        request,
  input  logic        granted
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // ---------------- JTAG oversampling ----------------
  logic [5:0] sync1, sync2, sync_prev;
  logic s_tck, s_tdi, s_shift, s_upd, s_ce1, s_ce2;
  logic tck_rise, upd_rise, ce1_rise;

  always_ff @(posedge system_clock or negedge JRSTN) begin
    if (!JRSTN) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      sync1     <= {JCE2, JCE1, JUPDATE, JSHIFT, JTDI, JTCK};
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign {s_ce2, s_ce1, s_upd, s_shift, s_tdi, s_tck} = sync2;
  assign tck_rise = s_tck & ~sync_prev[0];
  assign upd_rise = s_upd & ~sync_prev[3];
  assign ce1_rise = s_ce1 & ~sync_prev[4];

  logic unused_rti;
  assign unused_rti = &{1'b0, JRTI1, JRTI2};

  // ---------------- chains ----------------
  logic [35:0] sr;
  logic        bypass;
  logic        sel_chain2;
  logic [31:0] capture_word;

  always_ff @(posedge system_clock or negedge JRSTN) begin
    if (!JRSTN) begin
      sr         <= '0;
      bypass     <= 1'b0;
      sel_chain2 <= 1'b0;
    end else begin
      // Most recently enabled chain stays selected after its JCE drops.
      if (s_ce2 && !s_ce1)      sel_chain2 <= 1'b1;
      else if (s_ce1 && !s_ce2) sel_chain2 <= 1'b0;
      if (ce1_rise)                          sr <= {capture_word, 4'b0000};
      else if (tck_rise && s_ce1 && s_shift) sr <= {s_tdi, sr[35:1]};
      if (tck_rise && s_ce2 && s_shift) bypass <= s_tdi;
    end
  end

  assign JTDO1 = sr[0];
  assign JTDO2 = bypass;

  logic        exec;
  logic [3:0]  opcode;
  logic [31:0] payload;
  assign exec    = upd_rise && !sel_chain2;
  assign opcode  = sr[3:0];
  assign payload = sr[35:4];

  // ---------------- FIFOs ----------------
  logic [31:0]   wf_head, rf_head;
  logic [CW-1:0] wf_count, rf_count;
  logic          wf_full, wf_empty, rf_full, rf_empty;
  logic          wf_push, wf_pop, rf_push, rf_pop;

  jtag_word_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_wfifo (
    .clk(system_clock), .rst_n(JRSTN),
    .push(wf_push), .push_data(payload), .pop(wf_pop),
    .head(wf_head), .count(wf_count), .full(wf_full), .empty(wf_empty)
  );

  jtag_word_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_rfifo (
    .clk(system_clock), .rst_n(JRSTN),
    .push(rf_push), .push_data(address_dataIN), .pop(rf_pop),
    .head(rf_head), .count(rf_count), .full(rf_full), .empty(rf_empty)
  );

  // ---------------- configuration and status ----------------
  dma_state_e  dma_state, dma_next;
  logic [31:0] address_reg;
  logic [3:0]  be_reg;
  logic [7:0]  burst_reg;
  logic [7:0]  n_now;
  logic        err_sticky, read_pending;
  logic [31:0] status_word;
  logic        rd_start, take, bus_phase, rd_drop, err_set, status_rd;

  logic        cur_read;
  logic [7:0]  cur_n, beat_cnt, discard_cnt;
  logic        wr_beat, write_abort;

  assign n_now     = burst_beats(burst_reg, FIFO_DEPTH);
  assign status_rd = exec && (opcode == OP_STATUS);
  assign rd_start  = exec && (opcode == OP_READ) && !read_pending && (dma_state == DMA_IDLE);
  assign take      = (dma_state == DMA_IDLE) && (dma_next == DMA_REQ);
  assign bus_phase = (dma_state == DMA_BEGIN) || (dma_state == DMA_WDATA) ||
                     (dma_state == DMA_RDATA) || (dma_state == DMA_END);
  assign rd_drop   = (dma_state == DMA_RDATA) && data_validIN && rf_full;
  assign err_set   = (bus_phase && errorIN) || rd_drop;

  assign wf_push = exec && (opcode == OP_WRITE);
  assign rf_push = (dma_state == DMA_RDATA) && data_validIN;
  assign rf_pop  = exec && (opcode == OP_POP);

  assign wr_beat     = (dma_state == DMA_WDATA) && !busyIN && !errorIN && !wf_empty;
  assign write_abort = errorIN && !cur_read &&
                       ((dma_state == DMA_BEGIN) || (dma_state == DMA_WDATA));
  // Leftover beats of an aborted write are drained one per cycle while idle.
  assign wf_pop      = wr_beat || (discard_cnt != 8'd0);

  always_comb begin
    status_word = '0;
    status_word[ST_ACTIVE]  = (dma_state != DMA_IDLE);
    status_word[ST_ERROR]   = err_sticky;
    status_word[ST_REQUEST] = (dma_state == DMA_REQ);
    status_word[ST_WCOUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(wf_count);
    status_word[ST_RCOUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(rf_count);
  end

  always_ff @(posedge system_clock or negedge JRSTN) begin
    if (!JRSTN) begin
      address_reg  <= '0;
      be_reg       <= '0;
      burst_reg    <= '0;
      capture_word <= '0;
      err_sticky   <= 1'b0;
      read_pending <= 1'b0;
    end else begin
      // A new error in the same cycle as a status read survives the clear.
      err_sticky <= (err_sticky && !status_rd) || err_set;
      if (exec) begin
        case (opcode)
          OP_STATUS: capture_word <= status_word;
          OP_ADDR:   address_reg  <= payload;
          OP_BE:     be_reg       <= payload[3:0];
          OP_BURST:  burst_reg    <= payload[7:0];
          OP_POP:    capture_word <= rf_empty ? 32'd0 : rf_head;
          default:   ;
        endcase
      end
      if (rd_start)                  read_pending <= 1'b1;
      else if (take && read_pending) read_pending <= 1'b0;
    end
  end

  // ---------------- DMA state machine ----------------
  always_ff @(posedge system_clock or negedge JRSTN) begin
    if (!JRSTN) dma_state <= DMA_IDLE;
    else        dma_state <= dma_next;
  end

  always_comb begin
    dma_next = dma_state;
    case (dma_state)
      DMA_IDLE:  if (discard_cnt == 8'd0 && (read_pending || 8'(wf_count) >= n_now))
                   dma_next = DMA_REQ;
      DMA_REQ:   if (granted) dma_next = DMA_BEGIN;
      DMA_BEGIN: dma_next = errorIN ? DMA_IDLE : (cur_read ? DMA_RDATA : DMA_WDATA);
      DMA_WDATA: begin
        if (errorIN) dma_next = DMA_IDLE;
        else if (wr_beat && beat_cnt == cur_n - 8'd1) dma_next = DMA_END;
      end
      DMA_RDATA: if (errorIN || end_transactionIN) dma_next = DMA_IDLE;
      DMA_END:   dma_next = DMA_IDLE;
      default:   dma_next = DMA_IDLE;
    endcase
  end

  always_ff @(posedge system_clock or negedge JRSTN) begin
    if (!JRSTN) begin
      cur_read    <= 1'b0;
      cur_n       <= '0;
      beat_cnt    <= '0;
      discard_cnt <= '0;
    end else begin
      if (take) cur_read <= read_pending;
      if (dma_state == DMA_BEGIN) begin
        cur_n    <= n_now;
        beat_cnt <= '0;
      end else if (wr_beat) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (write_abort)
        discard_cnt <= (dma_state == DMA_BEGIN) ? n_now : cur_n - beat_cnt;
      else if (discard_cnt != 8'd0)
        discard_cnt <= discard_cnt - 8'd1;
    end
  end

  always_comb begin
    address_dataOUT      = '0;
    byte_enableOUT       = '0;
    busrt_sizeOUT        = '0;
    read_n_writeOUT      = 1'b0;
    begin_transactionOUT = 1'b0;
    end_transactionOUT   = 1'b0;
    data_validOUT        = 1'b0;
    request              = 1'b0;
    case (dma_state)
      DMA_REQ: request = 1'b1;
      DMA_BEGIN: begin
        begin_transactionOUT = 1'b1;
        address_dataOUT      = address_reg;
        byte_enableOUT       = be_reg;
        busrt_sizeOUT        = n_now - 8'd1;
        read_n_writeOUT      = cur_read;
      end
      DMA_WDATA: begin
        data_validOUT   = !wf_empty;
        address_dataOUT = wf_empty ? 32'd0 : wf_head;
      end
      DMA_END: end_transactionOUT = 1'b1;
      default: ;
    endcase
  end

  assign busyOUT = 1'b0;

endmodule

// File: tb/tb_jtag_bus_support.sv
module tb_jtag_bus_support;

  localparam int T_HALF = 60;
  localparam int EW     = 47;
  localparam logic [1:0] K_BEGIN = 2'd1;
  localparam logic [1:0] K_BEAT  = 2'd2;
  localparam logic [1:0] K_END   = 2'd3;

  logic        system_clock = 1'b0;
  logic        JRSTN, JTCK, JTDI, JSHIFT, JUPDATE, JCE1, JCE2, JRTI1, JRTI2;
  logic        JTDO1, JTDO2;
  logic [31:0] address_dataOUT;
  logic [3:0]  byte_enableOUT;
  logic [7:0]  busrt_sizeOUT;
  logic        read_n_writeOUT, begin_transactionOUT, end_transactionOUT;
  logic        data_validOUT, busyOUT;
  logic [31:0] address_dataIN;
  logic        end_transactionIN, data_validIN, busyIN, errorIN;
  logic        request, granted;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  jtag_bus_support #(.FIFO_DEPTH(16)) dut (
    .system_clock(system_clock), .JRSTN(JRSTN),
    .JTCK(JTCK), .JTDI(JTDI), .JSHIFT(JSHIFT), .JUPDATE(JUPDATE),
    .JCE1(JCE1), .JCE2(JCE2), .JRTI1(JRTI1), .JRTI2(JRTI2),
    .JTDO1(JTDO1), .JTDO2(JTDO2),
    .address_dataOUT(address_dataOUT), .byte_enableOUT(byte_enableOUT),
    .busrt_sizeOUT(busrt_sizeOUT), .read_n_writeOUT(read_n_writeOUT),
    .begin_transactionOUT(begin_transactionOUT), .end_transactionOUT(end_transactionOUT),
    .data_validOUT(data_validOUT), .busyOUT(busyOUT),
    .address_dataIN(address_dataIN), .end_transactionIN(end_transactionIN),
    .data_validIN(data_validIN), .busyIN(busyIN), .errorIN(errorIN),
    .request(request), .granted(granted)
  );

  // ---------------- clock ----------------
  always #5 system_clock = ~system_clock;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ev(input logic [1:0] kind, input logic rnw,
                                       input logic [3:0] be, input logic [7:0] burst,
                                       input logic [31:0] data);
    return {kind, rnw, be, burst, data};
  endfunction

  task automatic sb_pop(input string name, input logic [EW-1:0] obs);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected bus event %h, nothing expected", name, obs);
    end else begin
      e = exp_q.pop_front();
      check(name, 64'(obs), 64'(e));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge system_clock) begin
    if (JRSTN) begin
      if (begin_transactionOUT)
        sb_pop("bus_begin", ev(K_BEGIN, read_n_writeOUT, byte_enableOUT, busrt_sizeOUT, address_dataOUT));
      if (data_validOUT) begin
        if (busyIN) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_hold: beat %h offered with nothing expected", address_dataOUT);
          end else begin
            check("beat_hold", 64'(ev(K_BEAT, 1'b0, 4'h0, 8'h00, address_dataOUT)), 64'(exp_q[0]));
          end
        end else begin
          sb_pop("bus_beat", ev(K_BEAT, 1'b0, 4'h0, 8'h00, address_dataOUT));
        end
      end
      if (end_transactionOUT)
        sb_pop("bus_end", ev(K_END, 1'b0, 4'h0, 8'h00, address_dataOUT));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic jtag_scan(input logic [35:0] din, output logic [35:0] dout);
    JCE1 = 1'b1;
    #(2*T_HALF);
    JSHIFT = 1'b1;
    for (int i = 0; i < 36; i++) begin
      JTDI = din[i];
      #(T_HALF);
      dout[i] = JTDO1;
      JTCK = 1'b1;
      #(T_HALF);
      JTCK = 1'b0;
    end
    JSHIFT = 1'b0;
    JCE1   = 1'b0;
    #(2*T_HALF);
    JUPDATE = 1'b1;
    #(2*T_HALF);
    JUPDATE = 1'b0;
    #(2*T_HALF);
  endtask

  task automatic scan_expect(input string name, input logic [35:0] din, input logic [31:0] exp_word);
    logic [35:0] dout;
    jtag_scan(din, dout);
    check(name, 64'(dout), 64'({exp_word, 4'b0000}));
  endtask

  task automatic scan_only(input logic [35:0] din);
    logic [35:0] dout;
    jtag_scan(din, dout);
  endtask

  task automatic wait_request();
    int k;
    for (k = 0; k < 50; k++) begin
      @(posedge system_clock); #1;
      if (request) break;
    end
    check("request_up", 64'(request), 64'(1));
  endtask

  task automatic grant_pulse();
    granted = 1'b1;
    @(posedge system_clock); #1;
    granted = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge system_clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    JRSTN = 1'b0; JTCK = 1'b0; JTDI = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0;
    JCE1 = 1'b0; JCE2 = 1'b0; JRTI1 = 1'b0; JRTI2 = 1'b0;
    address_dataIN = '0; end_transactionIN = 1'b0; data_validIN = 1'b0;
    busyIN = 1'b0; errorIN = 1'b0; granted = 1'b0;

    idle_cycles(3);
    check("rst_request", 64'(request), 64'(0));
    check("rst_begin", 64'(begin_transactionOUT), 64'(0));
    check("rst_addr", 64'(address_dataOUT), 64'(0));
    check("rst_jtdo1", 64'(JTDO1), 64'(0));
    check("rst_busyout", 64'(busyOUT), 64'(0));
    JRSTN = 1'b1;
    idle_cycles(3);

    // chain 2 bypass
    JCE2 = 1'b1; #(2*T_HALF); JSHIFT = 1'b1;
    JTDI = 1'b1; #(T_HALF); JTCK = 1'b1; #(T_HALF); JTCK = 1'b0; #(T_HALF);
    check("bypass_one", 64'(JTDO2), 64'(1));
    JTDI = 1'b0; JTCK = 1'b1; #(T_HALF); JTCK = 1'b0; #(T_HALF);
    check("bypass_zero", 64'(JTDO2), 64'(0));
    JSHIFT = 1'b0; JCE2 = 1'b0; #(2*T_HALF);

    // configuration
    scan_expect("cap_after_reset", 36'h5_5555_5551, 32'h0);
    scan_only(36'h0_0000_00F2);
    scan_only(36'h0_0000_0013);
    scan_only(36'h0);
    scan_expect("status_after_reset", 36'h0, 32'h0);

    // single-beat write
    exp_q.push_back(ev(K_BEGIN, 1'b0, 4'hF, 8'h00, 32'h5555_5555));
    exp_q.push_back(ev(K_BEAT, 1'b0, 4'h0, 8'h00, 32'h00AB_CDEF));
    exp_q.push_back(ev(K_END, 1'b0, 4'h0, 8'h00, 32'h0));
    scan_only({32'h00AB_CDEF, 4'h8});
    wait_request();
    grant_pulse();
    idle_cycles(8);
    check("request_after_write", 64'(request), 64'(0));

    // single-beat read
    exp_q.push_back(ev(K_BEGIN, 1'b1, 4'hF, 8'h00, 32'h5555_5555));
    scan_only({32'h0, 4'h9});
    wait_request();
    grant_pulse();
    @(posedge system_clock); #1;
    data_validIN = 1'b1; address_dataIN = 32'hDEAD_BEEF;
    @(posedge system_clock); #1;
    data_validIN = 1'b0; address_dataIN = '0; end_transactionIN = 1'b1;
    @(posedge system_clock); #1;
    end_transactionIN = 1'b0;
    idle_cycles(4);
    scan_only(36'h0);
    scan_expect("status_rcount", {32'h0, 4'hA}, 32'h0001_0000);
    scan_expect("pop_data", 36'h0, 32'hDEAD_BEEF);

    // two-beat write with a busy stall on the first beat
    scan_only(36'h0_0000_0023);
    exp_q.push_back(ev(K_BEGIN, 1'b0, 4'hF, 8'h01, 32'h5555_5555));
    exp_q.push_back(ev(K_BEAT, 1'b0, 4'h0, 8'h00, 32'h1111_1111));
    exp_q.push_back(ev(K_BEAT, 1'b0, 4'h0, 8'h00, 32'h2222_2222));
    exp_q.push_back(ev(K_END, 1'b0, 4'h0, 8'h00, 32'h0));
    scan_only({32'h1111_1111, 4'h8});
    idle_cycles(10);
    check("req_below_n", 64'(request), 64'(0));
    scan_only({32'h2222_2222, 4'h8});
    wait_request();
    grant_pulse();
    for (int k = 0; k < 10; k++) begin
      @(posedge system_clock); #1;
      if (data_validOUT) break;
    end
    check("valid_seen", 64'(data_validOUT), 64'(1));
    busyIN = 1'b1;
    repeat (2) begin
      @(posedge system_clock); #1;
      check("busy_valid", 64'(data_validOUT), 64'(1));
      check("busy_data", 64'(address_dataOUT), 64'(32'h1111_1111));
    end
    @(posedge system_clock); #1;
    busyIN = 1'b0;
    idle_cycles(8);

    // bus error during a read
    exp_q.push_back(ev(K_BEGIN, 1'b1, 4'hF, 8'h01, 32'h5555_5555));
    scan_only({32'h0, 4'h9});
    wait_request();
    grant_pulse();
    @(posedge system_clock); #1;
    errorIN = 1'b1;
    @(posedge system_clock); #1;
    errorIN = 1'b0;
    idle_cycles(2);
    check("request_after_err", 64'(request), 64'(0));
    scan_only(36'h0);
    scan_expect("status_err", 36'h0, 32'h0000_0002);
    scan_expect("err_cleared", 36'h0, 32'h0);

    // reset in the middle of a write
    scan_only(36'h0_0000_0013);
    exp_q.push_back(ev(K_BEGIN, 1'b0, 4'hF, 8'h00, 32'h5555_5555));
    scan_only({32'h1234_5678, 4'h8});
    scan_only({32'h9ABC_DEF0, 4'h8});
    wait_request();
    grant_pulse();
    @(posedge system_clock); #1;
    JRSTN = 1'b0;
    #1;
    check("mid_rst_valid", 64'(data_validOUT), 64'(0));
    check("mid_rst_addr", 64'(address_dataOUT), 64'(0));
    check("mid_rst_request", 64'(request), 64'(0));
    check("mid_rst_end", 64'(end_transactionOUT), 64'(0));
    #20;
    JRSTN = 1'b1;
    idle_cycles(20);
    check("fifo_flushed", 64'(request), 64'(0));
    scan_only(36'h0);
    scan_expect("status_after_rst", 36'h0, 32'h0);

    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge system_clock);
    end
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_bus_support.md
Name: jtag_bus_support

Overview:
- Bridges a two-chain JTAG user-register interface (FPGA JTAG primitive style: JTCK/JTDI/JSHIFT/JUPDATE/JCE/JRTI) to the system bus as a DMA master.
- Chain 1 carries 36-bit instructions: 4-bit opcode plus 32-bit payload.
- Instructions set up address, byte-enable and burst registers, push write words, start reads and read back data and status.
- The whole block runs on system_clock; all JTAG pins are oversampled as data.

Parameters:
- FIFO_DEPTH, 16, word depth of the write FIFO and of the read FIFO; also the maximum burst beat count.

Ports:
- system_clock  in  1  sole clock; all state changes on its rising edge.
- JRSTN  in  1  asynchronous active-low reset of all state.
- JTCK  in  1  JTAG clock, sampled as data.
- JTDI  in  1  serial data in.
- JSHIFT  in  1  shift enable.
- JUPDATE  in  1  update strobe.
- JCE1, JCE2  in  1  chain 1 / chain 2 capture-enable.
- JRTI1, JRTI2  in  1  run-test-idle indicators; ignored.
- JTDO1  out  1  chain 1 serial data out.
- JTDO2  out  1  chain 2 (bypass) serial data out.
- address_dataOUT  out  32  bus address on begin, write data on beats.
- byte_enableOUT  out  4  byte enables.
- busrt_sizeOUT  out  8  beats minus 1.
- read_n_writeOUT  out  1  1 = read.
- begin_transactionOUT  out  1  transaction start pulse.
- end_transactionOUT  out  1  write end pulse.
- data_validOUT  out  1  write beat valid.
- busyOUT  out  1  slave-side stall; tied 0.
- address_dataIN  in  32  read data.
- end_transactionIN  in  1  slave ends a read.
- data_validIN  in  1  read beat valid.
- busyIN  in  1  slave stall.
- errorIN  in  1  bus error.
- request  out  1  bus request to arbiter.
- granted  in  1  arbiter grant.

Behaviour:
- Sampling
  - All JTAG inputs pass together through one 2-flop synchronizer stage.
  - A JTCK rising edge is detected from the synchronized value; JTAG actions use the synchronized input values sampled at that edge.
  - system_clock must be at least 2x JTCK.
- Chain 1 shift register SR[35:0]
  - Capture: on a sampled JCE1 rising edge, load SR = {capture_word[31:0], 4'b0000}.
  - Shift: on each JTCK rise with JCE1&JSHIFT, SR = {JTDI, SR[35:1]}.
  - JTDO1 = SR[0].
- Chain 2: 1-bit bypass flop; loads JTDI on a JTCK rise with JCE2&JSHIFT; JTDO2 = flop.
- Chain selection: the last chain with JCE asserted is the selected chain.
- Update: on a sampled JUPDATE rising edge with chain 1 selected, execute opcode = SR[3:0] with payload = SR[35:4] (one cycle).
- Opcodes
  - 0000: capture_word = status.
  - 0001: address_reg = payload.
  - 0010: byte_enable_reg = payload[3:0].
  - 0011: burst_reg = payload[7:0]; beats N = burst_reg, with 0 treated as 1 and values above FIFO_DEPTH clamped to FIFO_DEPTH.
  - 1000: push payload into the write FIFO; ignored when the FIFO is full.
  - 1001: start a read of N beats; ignored while a transaction is pending.
  - 1010: pop the read FIFO into capture_word; capture_word = 0 when the FIFO is empty.
  - Any other opcode: no operation.
- Status word: bit0 DMA active, bit1 sticky error, bit2 request, [7:3] 0, [12:8] write FIFO count, [15:13] 0, [20:16] read FIFO count, [31:21] 0.
  - Reading status (opcode 0000) clears the sticky error.
- DMA state machine: IDLE -> REQ -> BEGIN -> (WDATA | RDATA) -> END -> IDLE.
  - IDLE->REQ: write FIFO count >= N, or a pending read start.
  - REQ: request = 1 until granted is sampled high, then go to BEGIN.
  - BEGIN (1 cycle): begin_transactionOUT = 1; address_dataOUT = address_reg; byte_enableOUT, busrt_sizeOUT = N-1, read_n_writeOUT.
  - Registers are sampled at BEGIN; writes to them while the DMA is active affect the next transaction.
  - WDATA: drive the FIFO head with data_validOUT = 1; pop only on cycles with busyIN = 0; after N pops go to END.
  - END: end_transactionOUT pulses for 1 cycle.
  - RDATA: each cycle with data_validIN pushes address_dataIN into the read FIFO; when full, extra beats are dropped and the sticky error is set. end_transactionIN returns to IDLE.
  - errorIN in any bus phase sets the sticky error and returns to IDLE; an aborted write discards the remaining beats.
- All bus outputs are 0 outside their phases.
- address_reg is not auto-incremented.
- Reset values: all outputs 0, registers 0, FIFOs empty, state IDLE.

Decomposition:
- Shared package holds:
  - opcode constants OP_STATUS, OP_ADDR, OP_BE, OP_BURST, OP_WRITE, OP_READ, OP_POP;
  - the DMA state enum;
  - status bit positions.
- One sub-module, jtag_word_fifo: synchronous 32-bit FIFO with count output, instantiated twice (write and read).

Test Plan:
- Shift 36'h555555551 then update -> address_reg = 32'h55555555. Shift 36'hF2 -> byte_enable_reg = 4'hF. Shift 36'h13 -> burst_reg = 1.
- Opcode 0000, then shift 36 zeros on the next capture -> JTDO1 emits 4 zeros then the status word LSB-first; status reads 0 after reset.
- Opcode 1000 with payload 32'h00ABCDEF, N = 1 -> request = 1. A 1-cycle grant gives:
  - begin cycle: address 0x55555555, be F, burst 0, r_n_w 0;
  - next cycle: data_validOUT with 0x00ABCDEF;
  - then an end pulse; request = 0.
- Opcode 1001, grant, data_validIN with 0xDEADBEEF, then end_transactionIN -> read FIFO count 1. Opcode 1010, then capture and shift -> JTDO1 yields 0xDEADBEEF after 4 zero bits.
- Write with busyIN high for 3 cycles mid-beat -> data is held and data_validOUT stays 1; a beat is consumed only on a busyIN-low cycle.
- errorIN during RDATA -> return to IDLE and status bit1 = 1. JRSTN pulsed low mid-transaction -> all outputs 0 immediately and FIFOs emptied.
